// File: rtl/dlatch_checker.sv
// Clocked response checker for a D-latch: compares observed q against the
// transparent/hold behaviour implied by d and en, counting checks and errors.
module dlatch_checker #(
    parameter int CW     = 8,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          d,
    input  logic          en,
    input  logic          q,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] check_count,
    output logic [CW-1:0] first_err_cycle
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   err_count_reg, check_count_reg, first_err_reg, cyc_cnt_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic            fail_reg, exp_reg, exp_valid_reg, d_prev_reg, en_prev_reg;

    logic            enter, in_run, changed, do_check, expected_q, mismatch;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (stop)  state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Check qualification: only after inputs have been quiet for SETTLE cycles,
    // and in hold mode only once a value has actually been latched.
    always_comb begin
        enter      = 1'b0;
        in_run     = 1'b0;
        changed    = 1'b0;
        do_check   = 1'b0;
        expected_q = 1'b0;
        mismatch   = 1'b0;
        enter      = (state_reg != RUN) && start;
        in_run     = (state_reg == RUN);
        changed    = (d != d_prev_reg) || (en != en_prev_reg);
        expected_q = en ? d : exp_reg;
        do_check   = in_run && !changed && (settle_cnt_reg == '0) && (en || exp_valid_reg);
        mismatch   = do_check && (q !== expected_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            err_count_reg   <= '0;
            check_count_reg <= '0;
            first_err_reg   <= '0;
            cyc_cnt_reg     <= '0;
            settle_cnt_reg  <= '0;
            fail_reg        <= 1'b0;
            exp_reg         <= 1'b0;
            exp_valid_reg   <= 1'b0;
            d_prev_reg      <= 1'b0;
            en_prev_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (enter) begin
                err_count_reg   <= '0;
                check_count_reg <= '0;
                first_err_reg   <= '0;
                cyc_cnt_reg     <= '0;
                fail_reg        <= 1'b0;
                exp_valid_reg   <= 1'b0;
                settle_cnt_reg  <= SETTLE_V;
                d_prev_reg      <= d;
                en_prev_reg     <= en;
            end else if (in_run) begin
                cyc_cnt_reg <= sat_inc(cyc_cnt_reg);
                if (changed)
                    settle_cnt_reg <= SETTLE_V;
                else if (settle_cnt_reg != '0)
                    settle_cnt_reg <= settle_cnt_reg - 1'b1;
                if (do_check)
                    check_count_reg <= sat_inc(check_count_reg);
                if (mismatch) begin
                    err_count_reg <= sat_inc(err_count_reg);
                    fail_reg      <= 1'b1;
                    if (!fail_reg)
                        first_err_reg <= cyc_cnt_reg;
                end
                if (en) begin
                    exp_reg       <= d;
                    exp_valid_reg <= 1'b1;
                end
                d_prev_reg  <= d;
                en_prev_reg <= en;
            end
        end
    end

    assign busy            = (state_reg == RUN);
    assign done            = (state_reg == DONE);
    assign pass            = (state_reg == DONE) && (err_count_reg == '0);
    assign fail            = fail_reg;
    assign err_count       = err_count_reg;
    assign check_count     = check_count_reg;
    assign first_err_cycle = first_err_reg;

endmodule

// File: tb/tb_dlatch_checker.sv
// Randomized and directed bench for dlatch_checker against an edge-indexed
// behavioural model of the latch-checking rules.
module tb_dlatch_checker;

    localparam int CW     = 8;
    localparam int SETTLE = 1;

    logic          clk = 1'b0;
    logic          rst, start, stop, d, en, q;
    logic          busy, done, pass, fail;
    logic [CW-1:0] err_count, check_count, first_err_cycle;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;
    int  mode     = 0;   // 0 ideal latch, 1 q stuck at 0, 2 leaky (q follows d)
    logic ideal_q;

    always #5 clk = ~clk;

    dlatch_checker #(.CW(CW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .d(d), .en(en), .q(q),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .err_count(err_count), .check_count(check_count),
        .first_err_cycle(first_err_cycle)
    );

    always @(d or en) if (en) ideal_q = d;
    assign q = (mode == 0) ? ideal_q : (mode == 1) ? 1'b0 : d;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Reference model: checks allowed when more than SETTLE edges separate this
    // edge from the last input change (entry counts as a change).
    int   m_st = 0, m_edge = 0, m_last_chg = 0, m_steps = 0;
    int   m_err = 0, m_chk = 0, m_first = 0, m_cur;
    bit   m_fail = 0, m_have = 0;
    logic m_lat, m_dp, m_ep, m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_err = 0; m_chk = 0; m_first = 0; m_fail = 0;
        end else begin
            m_edge++;
            if (m_st != 1) begin
                if (start) begin
                    m_st = 1; m_err = 0; m_chk = 0; m_first = 0; m_fail = 0;
                    m_steps = 0; m_have = 0; m_last_chg = m_edge; m_dp = d; m_ep = en;
                end
            end else begin
                m_cur = m_steps;
                m_steps++;
                if (d !== m_dp || en !== m_ep)
                    m_last_chg = m_edge;
                else if ((m_edge - m_last_chg > SETTLE) && (en || m_have)) begin
                    m_chk++;
                    m_exp = en ? d : m_lat;
                    if (q !== m_exp) begin
                        if (!m_fail) m_first = sat(m_cur);
                        m_fail = 1;
                        m_err++;
                    end
                end
                if (en) begin m_lat = d; m_have = 1; end
                m_dp = d; m_ep = en;
                if (stop) m_st = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("busy",  32'(busy),  32'(m_st == 1));
            check_val("done",  32'(done),  32'(m_st == 2));
            check_val("pass",  32'(pass),  32'(m_st == 2 && m_err == 0));
            check_val("fail",  32'(fail),  32'(m_fail));
            check_val("err_count",   32'(err_count),   32'(sat(m_err)));
            check_val("check_count", 32'(check_count), 32'(sat(m_chk)));
            check_val("first_err",   32'(first_err_cycle), 32'(m_first));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_run();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic end_run();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    task automatic report(input string name);
        $display("%s: err=%0d checks=%0d first_err=%0d pass=%0d fail=%0d",
                 name, err_count, check_count, first_err_cycle, pass, fail);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; d = 1'b0; en = 1'b0;
        mon_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);

        // en low from entry: nothing ever latched, so no checks
        mode = 0; en = 1'b0; d = 1'b0;
        begin_run();
        for (int i = 0; i < 10; i++) begin d = ~d; step(1); end
        end_run();
        check_val("noexp_chk", 32'(check_count), 0);
        check_val("noexp_err", 32'(err_count), 0);
        check_val("noexp_pass", 32'(pass), 1);
        report("no_expect");

        // Ideal latch
        mode = 0; en = 1'b1; d = 1'b0;
        begin_run();
        for (int i = 0; i < 20; i++) begin if (i % 4 == 0) d = ~d; step(1); end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin d = ~d; step(1); end
        end_run();
        check_val("ideal_err", 32'(err_count), 0);
        check_val("ideal_chk_pos", 32'(check_count > 0), 1);
        check_val("ideal_pass", 32'(pass), 1);
        check_val("ideal_fail", 32'(fail), 0);
        report("ideal");

        // q stuck at 0, d rises when cyc_cnt is 3
        mode = 1; en = 1'b1; d = 1'b0;
        begin_run();
        step(3);
        d = 1'b1;
        step(8);
        end_run();
        check_val("stuck_err", 32'(err_count), 7);
        check_val("stuck_first", 32'(first_err_cycle), 5);
        check_val("stuck_fail", 32'(fail), 1);
        check_val("stuck_pass", 32'(pass), 0);
        report("stuck0");

        // Leaky latch: q follows d while en is low
        mode = 2; en = 1'b1; d = 1'b1;
        begin_run();
        step(3);
        en = 1'b0;
        step(2);
        d = 1'b0;
        step(5);
        end_run();
        check_val("leaky_err", 32'(err_count), 4);
        report("leaky");

        // Saturation
        mode = 1; en = 1'b1; d = 1'b1;
        begin_run();
        step(300);
        end_run();
        check_val("sat_err", 32'(err_count), 255);
        check_val("sat_chk", 32'(check_count), 255);
        report("saturate");

        // Random latch behaviour and stimulus
        for (int s = 0; s < 8; s++) begin
            mode = int'($urandom_range(0, 2));
            en = 1'($urandom); d = 1'($urandom);
            begin_run();
            for (int i = 0; i < int'($urandom_range(20, 60)); i++) begin
                if ($urandom_range(0, 3) == 0) d = ~d;
                if ($urandom_range(0, 5) == 0) en = ~en;
                step(1);
            end
            end_run();
            report($sformatf("random%0d mode%0d", s, mode));
        end

        // start and stop together in RUN: stop wins
        mode = 1; en = 1'b1; d = 1'b1;
        begin_run();
        step(5);
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        check_val("ss_done", 32'(done), 1);
        check_val("ss_busy", 32'(busy), 0);
        report("start_stop");
        begin_run();
        check_val("restart_err", 32'(err_count), 0);
        check_val("restart_chk", 32'(check_count), 0);
        check_val("restart_fail", 32'(fail), 0);
        check_val("restart_busy", 32'(busy), 1);
        report("restart");

        // Asynchronous reset mid-run, away from any clock edge
        step(6);
        #2 rst = 1'b1;
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_fail", 32'(fail), 0);
        check_val("rst_err", 32'(err_count), 0);
        check_val("rst_chk", 32'(check_count), 0);
        check_val("rst_first", 32'(first_err_cycle), 0);
        check_val("rst_done_pass", 32'({done, pass}), 0);
        report("async_reset");
        step(1);
        rst = 1'b0;
        step(2);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
